// File: rtl/camo_key_sequencer_if.sv
// Handshake bundle between the key/vector source and the camouflaged-datapath sequencer.
// The master drives key bits and test vectors, and the slave returns the capture results.
interface camo_key_sequencer_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3
);
    logic             key_valid;
    logic             key_ready;
    logic             key_bit;
    logic             vec_valid;
    logic             vec_ready;
    logic [IN_W-1:0]  vec_in;
    logic [OUT_W-1:0] vec_exp;
    logic             res_valid;
    logic [OUT_W-1:0] res_obs;
    logic             res_mismatch;

    modport master (
        output key_valid, key_bit, vec_valid, vec_in, vec_exp,
        input  key_ready, vec_ready, res_valid, res_obs, res_mismatch
    );

    modport slave (
        input  key_valid, key_bit, vec_valid, vec_in, vec_exp,
        output key_ready, vec_ready, res_valid, res_obs, res_mismatch
    );
endinterface

// File: rtl/camo_key_sequencer.sv
// Serially loads and atomically commits a CAMO function-select key, resets the datapath,
// then applies handshaked test vectors and scores the captured responses.
module camo_key_sequencer #(
    parameter int NUM_CAMO   = 3,
    parameter int SEL_W      = 2,
    parameter int IN_W       = 4,
    parameter int OUT_W      = 3,
    parameter int SETTLE     = 2,
    parameter int DP_RST_CYC = 2
) (
    input  logic                      CLK,
    input  logic                      NRST,
    camo_key_sequencer_if.slave       bus,
    output logic [NUM_CAMO*SEL_W-1:0] camo_sel,
    output logic [IN_W-1:0]           dp_in,
    output logic                      dp_rst_n,
    input  logic [OUT_W-1:0]          dp_out,
    output logic [7:0]                err_cnt,
    output logic                      key_loaded,
    output logic                      busy
);
    localparam int KEY_W = NUM_CAMO * SEL_W;
    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int RST_W = (DP_RST_CYC > 1) ? $clog2(DP_RST_CYC + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DPRST,
        READY,
        WAIT
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [CNT_W-1:0] bit_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic [OUT_W-1:0] exp_q;
    logic             res_valid;
    logic [OUT_W-1:0] res_obs;
    logic             res_mismatch;

    logic             key_take;
    logic             vec_take;
    logic [KEY_W-1:0] key_next;
    logic [CNT_W-1:0] cnt_next;

    assign bus.key_ready    = (state == IDLE) || (state == LOAD) || (state == READY);
    assign bus.vec_ready    = (state == READY) && !bus.key_valid;
    assign bus.res_valid    = res_valid;
    assign bus.res_obs      = res_obs;
    assign bus.res_mismatch = res_mismatch;
    assign busy             = !((state == IDLE) || (state == READY));

    assign key_take = bus.key_valid && bus.key_ready;
    assign vec_take = bus.vec_valid && bus.vec_ready;
    // Key arrives LSB first, so new bits enter at the top and drift down.
    assign key_next = {bus.key_bit, shadow[KEY_W-1:1]};
    assign cnt_next = (state == LOAD) ? bit_cnt + CNT_W'(1) : CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state        <= IDLE;
            shadow       <= '0;
            bit_cnt      <= '0;
            settle_cnt   <= '0;
            rst_cnt      <= '0;
            exp_q        <= '0;
            camo_sel     <= '0;
            dp_in        <= '0;
            dp_rst_n     <= 1'b1;
            res_valid    <= 1'b0;
            res_obs      <= '0;
            res_mismatch <= 1'b0;
            err_cnt      <= '0;
            key_loaded   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, LOAD, READY: begin
                    if (key_take) begin
                        shadow     <= key_next;
                        bit_cnt    <= cnt_next;
                        key_loaded <= 1'b0;
                        if (cnt_next == CNT_W'(KEY_W)) begin
                            camo_sel   <= key_next;
                            key_loaded <= 1'b1;
                            err_cnt    <= '0;
                            dp_rst_n   <= 1'b0;
                            rst_cnt    <= RST_W'(DP_RST_CYC - 1);
                            bit_cnt    <= '0;
                            state      <= DPRST;
                        end else begin
                            state <= LOAD;
                        end
                    end else if (vec_take) begin
                        dp_in      <= bus.vec_in;
                        exp_q      <= bus.vec_exp;
                        settle_cnt <= SET_W'(SETTLE - 1);
                        state      <= WAIT;
                    end
                end
                DPRST: begin
                    if (rst_cnt == '0) begin
                        dp_rst_n <= 1'b1;
                        state    <= READY;
                    end else begin
                        rst_cnt <= rst_cnt - RST_W'(1);
                    end
                end
                WAIT: begin
                    if (settle_cnt == '0) begin
                        res_obs      <= dp_out;
                        res_mismatch <= (dp_out != exp_q);
                        res_valid    <= 1'b1;
                        if ((dp_out != exp_q) && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state <= READY;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_camo_key_sequencer.sv
// Randomized transaction-level bench for camo_key_sequencer with a toy CAMO datapath and
// an abstract model of the committed key, error count and last capture.
module tb_camo_key_sequencer;
    localparam int KEY_W      = 6;
    localparam int SETTLE     = 2;
    localparam int DP_RST_CYC = 2;

    logic       CLK;
    logic       NRST;
    logic [5:0] camo_sel;
    logic [3:0] dp_in;
    logic       dp_rst_n;
    logic [2:0] dp_out;
    logic [7:0] err_cnt;
    logic       key_loaded;
    logic       busy;

    camo_key_sequencer_if #(.IN_W(4), .OUT_W(3)) bus ();

    camo_key_sequencer #(
        .NUM_CAMO(3), .SEL_W(2), .IN_W(4), .OUT_W(3),
        .SETTLE(SETTLE), .DP_RST_CYC(DP_RST_CYC)
    ) dut (
        .CLK(CLK), .NRST(NRST), .bus(bus), .camo_sel(camo_sel), .dp_in(dp_in),
        .dp_rst_n(dp_rst_n), .dp_out(dp_out), .err_cnt(err_cnt),
        .key_loaded(key_loaded), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [5:0] m_camo;
    logic [2:0] m_obs;
    logic       m_mis;
    int         m_err;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cell i picks AND/NAND/OR/XOR of inputs i and i+1.
    function automatic logic [2:0] dp_model(input logic [3:0] a, input logic [5:0] sel);
        logic [2:0] q;
        q = '0;
        for (int i = 0; i < 3; i++) begin
            case (sel[2*i +: 2])
                2'd0:    q[i] = a[i] & a[i+1];
                2'd1:    q[i] = ~(a[i] & a[i+1]);
                2'd2:    q[i] = a[i] | a[i+1];
                default: q[i] = a[i] ^ a[i+1];
            endcase
        end
        return q;
    endfunction

    assign dp_out = dp_rst_n ? dp_model(dp_in, camo_sel) : 3'b000;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state();
        m_camo = '0; m_obs = '0; m_mis = 1'b0; m_err = 0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_camo", 32'(camo_sel), 32'd0);
        checkOutput("rst_dp_in", 32'(dp_in), 32'd0);
        checkOutput("rst_dp_rst_n", 32'(dp_rst_n), 32'd1);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_res_obs", 32'(bus.res_obs), 32'd0);
        checkOutput("rst_res_mis", 32'(bus.res_mismatch), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_key_loaded", 32'(key_loaded), 32'd0);
        checkOutput("rst_key_ready", 32'(bus.key_ready), 32'd1);
        checkOutput("rst_vec_ready", 32'(bus.vec_ready), 32'd0);
    endtask

    task automatic apply_reset();
        NRST = 1'b0;
        tick();
        NRST = 1'b1;
        check_reset_state();
    endtask

    // Drives key beats [from, to); reaching beat KEY_W-1 commits the key.
    task automatic key_beats(input logic [5:0] key, input int from, input int to,
                             input int gap_after, input int gap_len);
        for (int i = from; i < to; i++) begin
            bus.key_valid = 1'b1;
            bus.key_bit   = key[i];
            #1;
            checkOutput("key_ready", 32'(bus.key_ready), 32'd1);
            tick();
            bus.key_valid = 1'b0;
            bus.key_bit   = 1'($urandom_range(1));
            if (i == KEY_W - 1) begin
                m_camo = key;
                m_err  = 0;
                checkOutput("commit_camo", 32'(camo_sel), 32'(key));
                checkOutput("commit_loaded", 32'(key_loaded), 32'd1);
                checkOutput("commit_err_clr", 32'(err_cnt), 32'd0);
            end else begin
                checkOutput("load_camo_hold", 32'(camo_sel), 32'(m_camo));
                checkOutput("load_loaded_low", 32'(key_loaded), 32'd0);
                checkOutput("load_busy", 32'(busy), 32'd1);
            end
            if (i + 1 == gap_after) begin
                repeat (gap_len) begin
                    tick();
                    checkOutput("gap_camo_hold", 32'(camo_sel), 32'(m_camo));
                    checkOutput("gap_loaded_low", 32'(key_loaded), 32'd0);
                end
            end
        end
        if (to == KEY_W) begin
            for (int c = 0; c < DP_RST_CYC; c++) begin
                checkOutput("dprst_low", 32'(dp_rst_n), 32'd0);
                checkOutput("dprst_vec_ready", 32'(bus.vec_ready), 32'd0);
                checkOutput("dprst_key_ready", 32'(bus.key_ready), 32'd0);
                tick();
            end
            checkOutput("ready_dp_rst_n", 32'(dp_rst_n), 32'd1);
            checkOutput("ready_vec_ready", 32'(bus.vec_ready), 32'd1);
            checkOutput("ready_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] vec, input logic wrong);
        logic [2:0] good;
        logic [2:0] vexp;
        good = dp_model(vec, m_camo);
        vexp = wrong ? (good ^ 3'(1 + $urandom_range(6))) : good;
        bus.vec_valid = 1'b1;
        bus.vec_in    = vec;
        bus.vec_exp   = vexp;
        #1;
        checkOutput("vec_ready", 32'(bus.vec_ready), 32'd1);
        tick();
        bus.vec_valid = 1'b0;
        bus.vec_in    = 4'($urandom);
        bus.vec_exp   = 3'($urandom);
        checkOutput("apply_dp_in", 32'(dp_in), 32'(vec));
        checkOutput("wait_busy", 32'(busy), 32'd1);
        checkOutput("wait_vec_ready", 32'(bus.vec_ready), 32'd0);
        checkOutput("early_res_valid", 32'(bus.res_valid), 32'd0);
        for (int k = 1; k < SETTLE; k++) begin
            tick();
            checkOutput("early_res_valid", 32'(bus.res_valid), 32'd0);
            checkOutput("settle_obs_hold", 32'(bus.res_obs), 32'(m_obs));
        end
        tick();
        m_obs = good;
        m_mis = wrong;
        if (wrong) m_err = (m_err < 255) ? m_err + 1 : 255;
        checkOutput("res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("res_obs", 32'(bus.res_obs), 32'(m_obs));
        checkOutput("res_mismatch", 32'(bus.res_mismatch), 32'(m_mis));
        checkOutput("err_cnt", 32'(err_cnt), 32'(m_err));
        checkOutput("res_vec_ready", 32'(bus.vec_ready), 32'd1);
        tick();
        checkOutput("res_pulse_end", 32'(bus.res_valid), 32'd0);
        checkOutput("res_obs_hold", 32'(bus.res_obs), 32'(m_obs));
        checkOutput("res_mis_hold", 32'(bus.res_mismatch), 32'(m_mis));
        checkOutput("dp_in_hold", 32'(dp_in), 32'(vec));
    endtask

    initial begin
        logic [5:0] key;
        logic [5:0] old_camo;
        logic [3:0] old_dp_in;

        NRST          = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_bit   = 1'b0;
        bus.vec_valid = 1'b0;
        bus.vec_in    = '0;
        bus.vec_exp   = '0;
        m_camo = '0; m_obs = '0; m_mis = 1'b0; m_err = 0;
        tick();
        apply_reset();

        key_beats(6'b011110, 0, KEY_W, -1, 0);
        applyStimulus(4'b1011, 1'b0);
        applyStimulus(4'b1011, 1'b1);
        repeat (10) applyStimulus(4'($urandom), 1'($urandom_range(1)));

        // Key beat and vector offered together: the key must win.
        key       = 6'($urandom);
        old_camo  = m_camo;
        old_dp_in = dp_in;
        bus.key_valid = 1'b1;
        bus.key_bit   = key[0];
        bus.vec_valid = 1'b1;
        bus.vec_in    = ~old_dp_in;
        #1;
        checkOutput("both_vec_ready", 32'(bus.vec_ready), 32'd0);
        checkOutput("both_key_ready", 32'(bus.key_ready), 32'd1);
        tick();
        bus.key_valid = 1'b0;
        bus.vec_valid = 1'b0;
        checkOutput("both_loaded_drop", 32'(key_loaded), 32'd0);
        checkOutput("both_camo_hold", 32'(camo_sel), 32'(old_camo));
        checkOutput("both_dp_in_hold", 32'(dp_in), 32'(old_dp_in));
        checkOutput("both_no_result", 32'(bus.res_valid), 32'd0);
        key_beats(key, 1, KEY_W, -1, 0);
        repeat (4) applyStimulus(4'($urandom), 1'($urandom_range(1)));

        key_beats(6'($urandom), 0, KEY_W, 3, 5);
        repeat (8) applyStimulus(4'($urandom), 1'($urandom_range(1)));

        // Reset while a vector is settling.
        bus.vec_valid = 1'b1;
        bus.vec_in    = 4'($urandom);
        bus.vec_exp   = 3'($urandom);
        tick();
        bus.vec_valid = 1'b0;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        apply_reset();
        tick();
        checkOutput("post_rst_res_valid", 32'(bus.res_valid), 32'd0);

        // Reset after four beats of a load discards the partial key.
        key_beats(6'($urandom), 0, 4, -1, 0);
        apply_reset();
        key_beats(6'($urandom), 0, KEY_W, -1, 0);
        repeat (5) applyStimulus(4'($urandom), 1'($urandom_range(1)));

        repeat (300) applyStimulus(4'($urandom), 1'b1);
        checkOutput("err_saturated", 32'(err_cnt), 32'd255);
        key_beats(6'($urandom), 0, KEY_W, -1, 0);
        repeat (4) applyStimulus(4'($urandom), 1'($urandom_range(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
